seg7_time_reader: RTL and testbench

- Receive-side counterpart of the stopwatch 7-segment display path.
- Samples the four hh:mm segment buses the stopwatch drives, glitch-filters them, and decodes the segment patterns back to BCD and binary minutes.
- Classifies each accepted change as a single-minute step or a jump.
- Used as an on-chip display checker and as the readback source for self-test logic.

---
 rtl/seg7_time_reader.sv | 174 +++++++++++++++++
 tb/tb_seg7_time_reader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seg7_time_reader.sv
// Display-side readback of the hh:mm 7-segment buses.
// Glitch-filters the four segment buses, decodes them back to BCD and
// binary minutes, and flags each accepted change as a one-minute step or a jump.
//
// state  | meaning
// WAIT   | new pattern captured, counting identical samples
// EVAL   | pattern stable; decode and classify it this cycle
// LOCKED | pattern already evaluated; ignore until it changes
module seg7_time_reader #(
   parameter int STABLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = 1'b1,
   parameter int MAX_HR        = 99
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [6:0]  seg_hr_tens,
   input  logic [6:0]  seg_hr_ones,
   input  logic [6:0]  seg_min_tens,
   input  logic [6:0]  seg_min_ones,
   output logic [3:0]  hr_tens,
   output logic [3:0]  hr_ones,
   output logic [3:0]  min_tens,
   output logic [3:0]  min_ones,
   output logic [12:0] total_min,
   output logic        upd,
   output logic        step,
   output logic        jump,
   output logic        bad,
   output logic [7:0]  err_cnt
);

   typedef enum logic [1:0] {WAIT, EVAL, LOCKED} state_t;

   localparam logic [7:0]  CNT_LAST  = 8'(STABLE_CYCLES - 1);
   localparam logic [6:0]  MAX_HR_V  = 7'(MAX_HR);
   localparam logic [12:0] MAX_TOTAL = 13'((MAX_HR + 1) * 60 - 1);

   // Returns {valid, digit}; blank is only accepted where allow_blank is set.
   function automatic logic [4:0] dec_digit(input logic [6:0] raw, input logic allow_blank);
      logic [6:0] s;
      s = ACTIVE_LOW ? ~raw : raw;
      case (s)
         7'h3F:   dec_digit = {1'b1, 4'd0};
         7'h06:   dec_digit = {1'b1, 4'd1};
         7'h5B:   dec_digit = {1'b1, 4'd2};
         7'h4F:   dec_digit = {1'b1, 4'd3};
         7'h66:   dec_digit = {1'b1, 4'd4};
         7'h6D:   dec_digit = {1'b1, 4'd5};
         7'h7D:   dec_digit = {1'b1, 4'd6};
         7'h07:   dec_digit = {1'b1, 4'd7};
         7'h7F:   dec_digit = {1'b1, 4'd8};
         7'h6F:   dec_digit = {1'b1, 4'd9};
         7'h00:   dec_digit = {allow_blank, 4'd0};
         default: dec_digit = {1'b0, 4'd0};
      endcase
   endfunction

   state_t      state, state_nxt;
   logic [27:0] cand, cand_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic        have_prev, have_prev_nxt;
   logic [3:0]  hr_tens_nxt, hr_ones_nxt, min_tens_nxt, min_ones_nxt;
   logic [12:0] total_nxt;
   logic        upd_nxt, step_nxt, jump_nxt, bad_nxt;
   logic [7:0]  err_nxt;

   logic [27:0] sample;
   logic [4:0]  d_ht, d_ho, d_mt, d_mo;
   logic [6:0]  hour;
   logic [12:0] new_total, prev_inc;
   logic        legal;

   assign sample = {seg_hr_tens, seg_hr_ones, seg_min_tens, seg_min_ones};

   // Decode the held candidate; only consumed while in EVAL.
   always_comb begin
      d_ht      = dec_digit(cand[27:21], 1'b1);
      d_ho      = dec_digit(cand[20:14], 1'b0);
      d_mt      = dec_digit(cand[13:7],  1'b0);
      d_mo      = dec_digit(cand[6:0],   1'b0);
      hour      = 7'(d_ht[3:0]) * 7'd10 + 7'(d_ho[3:0]);
      new_total = 13'(hour) * 13'd60 + 13'(d_mt[3:0]) * 13'd10 + 13'(d_mo[3:0]);
      prev_inc  = (total_min == MAX_TOTAL) ? 13'd0 : total_min + 13'd1;
      legal     = d_ht[4] && d_ho[4] && d_mt[4] && d_mo[4] &&
                  (d_mt[3:0] <= 4'd5) && (hour <= MAX_HR_V);
   end

   // Next-state: filter sequencing plus the EVAL decision.
   always_comb begin
      state_nxt     = state;
      cand_nxt      = cand;
      cnt_nxt       = cnt;
      have_prev_nxt = have_prev;
      hr_tens_nxt   = hr_tens;
      hr_ones_nxt   = hr_ones;
      min_tens_nxt  = min_tens;
      min_ones_nxt  = min_ones;
      total_nxt     = total_min;
      err_nxt       = err_cnt;
      upd_nxt       = 1'b0;
      step_nxt      = 1'b0;
      jump_nxt      = 1'b0;
      bad_nxt       = 1'b0;

      if (state == EVAL) begin
         state_nxt = LOCKED;
         if (!legal) begin
            bad_nxt = 1'b1;
            if (err_cnt != 8'hFF) err_nxt = err_cnt + 8'd1;
         end else if (!have_prev || (new_total != total_min)) begin
            hr_tens_nxt   = d_ht[3:0];
            hr_ones_nxt   = d_ho[3:0];
            min_tens_nxt  = d_mt[3:0];
            min_ones_nxt  = d_mo[3:0];
            total_nxt     = new_total;
            upd_nxt       = 1'b1;
            have_prev_nxt = 1'b1;
            if (have_prev) begin
               step_nxt = (new_total == prev_inc);
               jump_nxt = (new_total != prev_inc);
            end
         end
      end

      // A pattern change during EVAL restarts filtering; the EVAL result above still stands.
      if (en) begin
         if (sample != cand) begin
            cand_nxt  = sample;
            cnt_nxt   = 8'd0;
            state_nxt = (STABLE_CYCLES == 1) ? EVAL : WAIT;
         end else if (state == WAIT) begin
            cnt_nxt = cnt + 8'd1;
            if ({1'b0, cnt} + 9'd1 >= {1'b0, CNT_LAST}) state_nxt = EVAL;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= WAIT;
         cand      <= '0;
         cnt       <= '0;
         have_prev <= 1'b0;
         hr_tens   <= '0;
         hr_ones   <= '0;
         min_tens  <= '0;
         min_ones  <= '0;
         total_min <= '0;
         err_cnt   <= '0;
         upd       <= 1'b0;
         step      <= 1'b0;
         jump      <= 1'b0;
         bad       <= 1'b0;
      end else begin
         state     <= state_nxt;
         cand      <= cand_nxt;
         cnt       <= cnt_nxt;
         have_prev <= have_prev_nxt;
         hr_tens   <= hr_tens_nxt;
         hr_ones   <= hr_ones_nxt;
         min_tens  <= min_tens_nxt;
         min_ones  <= min_ones_nxt;
         total_min <= total_nxt;
         err_cnt   <= err_nxt;
         upd       <= upd_nxt;
         step      <= step_nxt;
         jump      <= jump_nxt;
         bad       <= bad_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_time_reader.sv
// Directed bench for seg7_time_reader with active-low segment patterns.
module tb_seg7_time_reader;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [6:0]  seg_hr_tens, seg_hr_ones, seg_min_tens, seg_min_ones;
   logic [3:0]  hr_tens, hr_ones, min_tens, min_ones;
   logic [12:0] total_min;
   logic        upd, step, jump, bad;
   logic [7:0]  err_cnt;

   int n_total = 0;
   int n_bad   = 0;
   int n_upd, n_step, n_jump, n_badp;

   seg7_time_reader #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1), .MAX_HR(99)) dut (
      .clk(clk), .rst(rst), .en(en),
      .seg_hr_tens(seg_hr_tens), .seg_hr_ones(seg_hr_ones),
      .seg_min_tens(seg_min_tens), .seg_min_ones(seg_min_ones),
      .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens), .min_ones(min_ones),
      .total_min(total_min), .upd(upd), .step(step), .jump(jump), .bad(bad),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      n_upd = 0; n_step = 0; n_jump = 0; n_badp = 0;
   endtask

   // Advance n edges, sampling 1 time unit after each edge.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (upd === 1'b1)  n_upd++;
         if (step === 1'b1) n_step++;
         if (jump === 1'b1) n_jump++;
         if (bad === 1'b1)  n_badp++;
      end
   endtask

   task automatic set(input logic [6:0] ht, input logic [6:0] ho, input logic [6:0] mt, input logic [6:0] mo);
      seg_hr_tens = ht; seg_hr_ones = ho; seg_min_tens = mt; seg_min_ones = mo;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0;
      set(7'h7F, 7'h7F, 7'h7F, 7'h7F);
      clr();
      cyc(2);
      chk("rst_hr_tens", hr_tens, 0);
      chk("rst_min_ones", min_ones, 0);
      chk("rst_total", total_min, 0);
      chk("rst_upd", upd, 0);
      chk("rst_err", err_cnt, 0);

      // 12:58, exact latency
      rst = 1'b0; en = 1'b1;
      set(7'h79, 7'h24, 7'h12, 7'h00);
      clr();
      cyc(4);
      chk("t1_no_early_upd", n_upd, 0);
      cyc(1);
      chk("t1_upd", upd, 1);
      chk("t1_step", step, 0);
      chk("t1_jump", jump, 0);
      chk("t1_hr_tens", hr_tens, 1);
      chk("t1_hr_ones", hr_ones, 2);
      chk("t1_min_tens", min_tens, 5);
      chk("t1_min_ones", min_ones, 8);
      chk("t1_total", total_min, 778);
      cyc(1);
      chk("t1_upd_one_cycle", upd, 0);

      // 12:59 then 13:00 as steps
      set(7'h79, 7'h24, 7'h12, 7'h10);
      clr(); cyc(8);
      chk("t2a_upd", n_upd, 1);
      chk("t2a_step", n_step, 1);
      chk("t2a_jump", n_jump, 0);
      chk("t2a_total", total_min, 779);
      set(7'h79, 7'h30, 7'h40, 7'h40);
      clr(); cyc(8);
      chk("t2b_step", n_step, 1);
      chk("t2b_total", total_min, 780);
      chk("t2b_hr_ones", hr_ones, 3);
      chk("t2b_min_ones", min_ones, 0);

      // 2-cycle glitch is filtered
      clr();
      set(7'h79, 7'h30, 7'h40, 7'h78);
      cyc(2);
      set(7'h79, 7'h30, 7'h40, 7'h40);
      cyc(8);
      chk("t3_glitch_upd", n_upd, 0);
      chk("t3_glitch_bad", n_badp, 0);
      chk("t3_glitch_total", total_min, 780);
      // same glitch with sampling disabled
      en = 1'b0; clr();
      set(7'h79, 7'h30, 7'h40, 7'h78);
      cyc(2);
      set(7'h79, 7'h30, 7'h40, 7'h40);
      cyc(6);
      en = 1'b1;
      cyc(6);
      chk("t3_en0_upd", n_upd, 0);
      chk("t3_en0_bad", n_badp, 0);
      chk("t3_en0_min_ones", min_ones, 0);

      // blank min_ones is illegal
      set(7'h79, 7'h30, 7'h40, 7'h7F);
      clr(); cyc(8);
      chk("t4_bad", n_badp, 1);
      chk("t4_err_cnt", err_cnt, 1);
      chk("t4_upd", n_upd, 0);
      chk("t4_total_hold", total_min, 780);
      set(7'h79, 7'h30, 7'h40, 7'h40);
      clr(); cyc(8);
      chk("t4_restore_upd", n_upd, 0);
      chk("t4_restore_bad", n_badp, 0);

      // 99:59 jump, wrap to blank-0:00 step, then 05:00 jump
      set(7'h10, 7'h10, 7'h12, 7'h10);
      clr(); cyc(8);
      chk("t5a_upd", n_upd, 1);
      chk("t5a_jump", n_jump, 1);
      chk("t5a_step", n_step, 0);
      chk("t5a_total", total_min, 5999);
      set(7'h7F, 7'h40, 7'h40, 7'h40);
      clr(); cyc(8);
      chk("t5b_upd", n_upd, 1);
      chk("t5b_step", n_step, 1);
      chk("t5b_jump", n_jump, 0);
      chk("t5b_total", total_min, 0);
      chk("t5b_hr_tens", hr_tens, 0);
      set(7'h40, 7'h12, 7'h40, 7'h40);
      clr(); cyc(8);
      chk("t5c_jump", n_jump, 1);
      chk("t5c_total", total_min, 300);
      chk("t5c_hr_ones", hr_ones, 5);

      // reset mid-filter
      set(7'h79, 7'h24, 7'h12, 7'h00);
      clr(); cyc(2);
      rst = 1'b1;
      cyc(2);
      chk("t6_rst_upd", n_upd, 0);
      chk("t6_rst_total", total_min, 0);
      chk("t6_rst_err", err_cnt, 0);
      chk("t6_rst_hr_ones", hr_ones, 0);
      rst = 1'b0;
      clr(); cyc(8);
      chk("t6_upd", n_upd, 1);
      chk("t6_step", n_step, 0);
      chk("t6_jump", n_jump, 0);
      chk("t6_total", total_min, 778);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
